sort_stream_kv: RTL and testbench
=================================

// Module: sort_stream_kv
// PURPOSE
//  Reusable odd-even transposition (systolic) sorter for key/tag records, framed by valid/ready handshakes.
//  Accepts a frame of 1..SIZE records, sorts it stably in ascending or descending key order, then streams it out.
//  Sits between a framed producer and a consumer. Either side may stall; short frames are allowed.
// PARAMETERS
//  SIZE    8   number of sorting cells = maximum frame length (>=2)
//  KEY_W   32  key width; comparison is unsigned
//  TAG_W   8   payload carried with each key; never compared
// PORTS
//  clk        in   1        clock
//  rst_n      in   1        synchronous active-low reset
//  descend    in   1        order select, sampled with the first accepted record of a frame (1 = largest first)
//  in_valid   in   1        input record valid
//  in_ready   out  1        block can accept a record
//  in_key     in   KEY_W    record key
//  in_tag     in   TAG_W    record payload
//  in_last    in   1        accepted record is the last of the frame
//  out_valid  out  1        output record valid
//  out_ready  in   1        consumer accepts output record
//  out_key    out  KEY_W    sorted key
//  out_tag    out  TAG_W    payload travelling with out_key
//  out_last   out  1        final record of the sorted frame
//  busy       out  1        high in SORT or OUT
// BEHAVIOUR
//  Reset (rst_n=0 at posedge clk):
//   - state=LOAD, count=0; all cell valid bits cleared.
//   - in_ready=0 during the reset cycle, then 1; out_valid=0, out_last=0, busy=0, out_key/out_tag=0.
//   - Reset mid-frame discards all stored records; no partial output is produced.
//  Storage: cell[0..SIZE-1] each holds {v, key, tag}; count is $clog2(SIZE+1) bits.
//  LOAD (in_ready=1):
//   - A record is accepted when in_valid & in_ready. It is written to cell[count], with v=1, and count increments.
//   - The first accepted record latches descend into the mode register.
//   - Go to SORT next cycle when the accepted record has in_last=1 or count reaches SIZE.
//     With count==SIZE, in_last is ignored.
//  SORT (in_ready=0):
//   - Phase p alternates: even phases compare pairs (0,1),(2,3),...; odd phases compare (1,2),(3,4),...
//   - Swap pair (i,i+1) only when strictly out of order:
//     - v[i]=0 & v[i+1]=1 -> swap (invalid cells sink to the end).
//     - Both valid: ascending swaps if key[i] > key[i+1]; descending swaps if key[i] < key[i+1].
//     - Equal keys never swap, so the sort is stable in arrival order.
//   - Exit to OUT after two consecutive phases with no swap, or after SIZE phases, whichever comes first.
//   - SORT takes 2..SIZE cycles.
//  OUT:
//   - out_valid=1; out_key/out_tag = cell[0]; out_last=1 when count==1.
//   - On out_valid & out_ready: cell[i] <= cell[i+1], cell[SIZE-1].v <= 0, count decrements.
//   - When the out_last record is accepted, return to LOAD next cycle with in_ready=1.
//   - Outputs hold stable while out_ready=0.
//  Latency: for N records accepted back to back with no stall, the first out_valid occurs at most SIZE+1 cycles after the cycle the last record is accepted.
//  Throughput: one frame in flight. No input is accepted in SORT or OUT.
//  Simultaneous in_valid with in_last on the SIZE-th record: accepted normally, single transition to SORT.
//  A frame of 1 record: SORT exits after 2 phases and outputs the record with out_last=1.
// TESTING
//  1. SIZE=4, KEY_W=8, ascending: keys 7,3,9,1, last on 1 -> out 1,3,7,9; out_last only on 9.
//  2. descend=1 with keys 7,3,9,1 -> out 9,7,3,1; toggling descend mid-frame has no effect.
//  3. Stability: keys/tags (5,A),(2,B),(5,C),(2,D) ascending -> (2,B),(2,D),(5,A),(5,C).
//  4. Short frame: keys 4,2 with in_last on 2 -> out 2,4; out_last on 4; next frame accepted afterwards.
//  5. out_ready toggled 1/0 pseudo-randomly -> no loss or duplication; outputs stable while stalled; in_ready=0 throughout OUT.
//  6. rst_n=0 asserted in SORT after 2 records, then a new frame 8,6 -> out 6,8 only; no stale records appear.

Source files
------------

// File: rtl/sort_stream_kv.sv
// Framed key/tag sorter: loads up to SIZE records, sorts them stably with an
// odd-even transposition network, then streams them out smallest (or largest) first.
module sort_stream_kv #(
  parameter int unsigned SIZE  = 8,
  parameter int unsigned KEY_W = 32,
  parameter int unsigned TAG_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             descend,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [KEY_W-1:0] in_key,
  input  logic [TAG_W-1:0] in_tag,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [KEY_W-1:0] out_key,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_last,
  output logic             busy
);

  localparam int unsigned CNT_W = $clog2(SIZE + 1);

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    SORT = 2'd1,
    OUT  = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] count, count_nxt;
  logic [CNT_W-1:0] pcnt, pcnt_nxt;
  logic             desc_q, desc_nxt;
  logic             phase, phase_nxt;
  logic             quiet, quiet_nxt;
  logic             any_swap;

  logic             cv     [SIZE];
  logic [KEY_W-1:0] ck     [SIZE];
  logic [TAG_W-1:0] ct     [SIZE];
  logic             cv_nxt [SIZE];
  logic [KEY_W-1:0] ck_nxt [SIZE];
  logic [TAG_W-1:0] ct_nxt [SIZE];

  logic in_ready_nxt, out_valid_nxt, out_last_nxt, busy_nxt;
  logic do_swap;

  // Next-state, cell network and registered-output decode
  always_comb begin
    state_nxt = state;
    count_nxt = count;
    pcnt_nxt  = pcnt;
    desc_nxt  = desc_q;
    phase_nxt = phase;
    quiet_nxt = quiet;
    any_swap  = 1'b0;
    do_swap   = 1'b0;
    cv_nxt    = cv;
    ck_nxt    = ck;
    ct_nxt    = ct;

    case (state)
      LOAD: begin
        if (in_valid && in_ready) begin
          for (int i = 0; i < int'(SIZE); i++) begin
            if (count == CNT_W'(i)) begin
              cv_nxt[i] = 1'b1;
              ck_nxt[i] = in_key;
              ct_nxt[i] = in_tag;
            end
          end
          if (count == '0) desc_nxt = descend;
          count_nxt = count + CNT_W'(1);
          if (in_last || (count_nxt == CNT_W'(SIZE))) begin
            state_nxt = SORT;
            phase_nxt = 1'b0;
            quiet_nxt = 1'b0;
            pcnt_nxt  = '0;
          end
        end
      end

      SORT: begin
        // Pairs are disjoint within a phase, so every pair reads the current cells
        for (int i = 0; i < int'(SIZE) - 1; i++) begin
          if (1'(i) == phase) begin
            if (!cv[i] && cv[i+1])
              do_swap = 1'b1;
            else if (cv[i] && cv[i+1])
              do_swap = desc_q ? (ck[i] < ck[i+1]) : (ck[i] > ck[i+1]);
            else
              do_swap = 1'b0;
            if (do_swap) begin
              cv_nxt[i]   = cv[i+1];
              ck_nxt[i]   = ck[i+1];
              ct_nxt[i]   = ct[i+1];
              cv_nxt[i+1] = cv[i];
              ck_nxt[i+1] = ck[i];
              ct_nxt[i+1] = ct[i];
            end
            any_swap = any_swap | do_swap;
          end
        end
        phase_nxt = ~phase;
        pcnt_nxt  = pcnt + CNT_W'(1);
        quiet_nxt = ~any_swap;
        if ((!any_swap && quiet) || (pcnt == CNT_W'(SIZE - 1))) state_nxt = OUT;
      end

      OUT: begin
        if (out_valid && out_ready) begin
          for (int i = 0; i < int'(SIZE) - 1; i++) begin
            cv_nxt[i] = cv[i+1];
            ck_nxt[i] = ck[i+1];
            ct_nxt[i] = ct[i+1];
          end
          cv_nxt[SIZE-1] = 1'b0;
          ck_nxt[SIZE-1] = '0;
          ct_nxt[SIZE-1] = '0;
          count_nxt      = count - CNT_W'(1);
          if (count == CNT_W'(1)) state_nxt = LOAD;
        end
      end

      default: state_nxt = LOAD;
    endcase

    in_ready_nxt  = (state_nxt == LOAD);
    out_valid_nxt = (state_nxt == OUT);
    out_last_nxt  = (state_nxt == OUT) && (count_nxt == CNT_W'(1));
    busy_nxt      = (state_nxt != LOAD);
  end

  // State and storage registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= LOAD;
      count     <= '0;
      pcnt      <= '0;
      desc_q    <= 1'b0;
      phase     <= 1'b0;
      quiet     <= 1'b0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
      for (int i = 0; i < int'(SIZE); i++) begin
        cv[i] <= 1'b0;
        ck[i] <= '0;
        ct[i] <= '0;
      end
    end else begin
      state     <= state_nxt;
      count     <= count_nxt;
      pcnt      <= pcnt_nxt;
      desc_q    <= desc_nxt;
      phase     <= phase_nxt;
      quiet     <= quiet_nxt;
      in_ready  <= in_ready_nxt;
      out_valid <= out_valid_nxt;
      out_last  <= out_last_nxt;
      busy      <= busy_nxt;
      cv        <= cv_nxt;
      ck        <= ck_nxt;
      ct        <= ct_nxt;
    end
  end

  assign out_key = ck[0];
  assign out_tag = ct[0];

endmodule

// File: tb/tb_sort_stream_kv.sv
// Scoreboard bench for sort_stream_kv: frames are sorted by a stable insertion
// model; a monitor compares every presented output against the expected queue.
module tb_sort_stream_kv;

  localparam int unsigned SIZE  = 4;
  localparam int unsigned KEY_W = 8;
  localparam int unsigned TAG_W = 8;

  typedef struct packed {
    logic [KEY_W-1:0] key;
    logic [TAG_W-1:0] tag;
    logic             last;
  } rec_t;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             descend;
  logic             in_valid;
  logic             in_ready;
  logic [KEY_W-1:0] in_key;
  logic [TAG_W-1:0] in_tag;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [KEY_W-1:0] out_key;
  logic [TAG_W-1:0] out_tag;
  logic             out_last;
  logic             busy;

  int   total = 0;
  int   bad   = 0;
  rec_t sb[$];
  logic [KEY_W-1:0] fk [SIZE];
  logic [TAG_W-1:0] ft [SIZE];

  sort_stream_kv #(.SIZE(SIZE), .KEY_W(KEY_W), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst_n(rst_n), .descend(descend),
    .in_valid(in_valid), .in_ready(in_ready), .in_key(in_key), .in_tag(in_tag),
    .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready),
    .out_key(out_key), .out_tag(out_tag), .out_last(out_last), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Called at a negedge; returns at a negedge with in_ready high, or reports a timeout
  task automatic wait_ready();
    int k = 0;
    while (!in_ready && k < 300) begin
      @(negedge clk);
      k++;
    end
    if (!in_ready) check("in_ready_timeout", 32'(in_ready), 32'd1);
  endtask

  task automatic send_frame(input int n, input bit d, input bit tog, input bit push);
    rec_t q[$];
    rec_t r;
    int   pos;
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      wait_ready();
      in_valid = 1'b1;
      in_key   = fk[i];
      in_tag   = ft[i];
      in_last  = (i == n - 1);
      descend  = (tog && i > 0) ? ~d : d;
      @(negedge clk);
      in_valid = 1'b0;
      in_last  = 1'b0;
      descend  = $urandom_range(0, 1) != 0;
    end
    check("busy_after_frame", 32'(busy), 32'd1);
    if (push) begin
      // Insert each record after every record it does not strictly precede
      for (int i = 0; i < n; i++) begin
        r.key  = fk[i];
        r.tag  = ft[i];
        r.last = 1'b0;
        pos = 0;
        while (pos < q.size() && !(d ? (q[pos].key < r.key) : (q[pos].key > r.key))) pos++;
        q.insert(pos, r);
      end
      q[q.size()-1].last = 1'b1;
      foreach (q[j]) sb.push_back(q[j]);
    end
  endtask

  task automatic set4(input logic [7:0] k0, k1, k2, k3, input logic [7:0] t0, t1, t2, t3);
    fk[0] = k0; fk[1] = k1; fk[2] = k2; fk[3] = k3;
    ft[0] = t0; ft[1] = t1; ft[2] = t2; ft[3] = t3;
  endtask

  task automatic drain();
    int k = 0;
    while (sb.size() != 0 && k < 2000) begin
      @(negedge clk);
      k++;
    end
    check("drain_timeout", 32'(sb.size()), 32'd0);
    repeat (3) @(negedge clk);
  endtask

  task automatic check_idle_reset(input string tag);
    check({tag, "_in_ready"}, 32'(in_ready), 32'd0);
    check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_out_last"}, 32'(out_last), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_out_key"}, 32'(out_key), 32'd0);
    check({tag, "_out_tag"}, 32'(out_tag), 32'd0);
  endtask

  // Monitor: randomise out_ready, compare whatever the DUT presents against the queue head
  initial begin
    rec_t e;
    out_ready = 1'b0;
    forever begin
      @(negedge clk);
      out_ready = $urandom_range(0, 1) != 0;
      if (rst_n === 1'b1 && out_valid === 1'b1) begin
        check("in_ready_during_out", 32'(in_ready), 32'd0);
        if (sb.size() == 0) begin
          check("unexpected_output", 32'(out_key), 32'hFFFF_FFFF);
        end else begin
          e = sb[0];
          check("out_record", {15'd0, out_key, out_tag, out_last}, {15'd0, e.key, e.tag, e.last});
          if (out_ready) void'(sb.pop_front());
        end
      end
    end
  end

  initial begin
    rst_n    = 1'b0;
    descend  = 1'b0;
    in_valid = 1'b0;
    in_key   = '0;
    in_tag   = '0;
    in_last  = 1'b0;
    repeat (3) @(negedge clk);
    check_idle_reset("reset");
    rst_n = 1'b1;
    @(negedge clk);

    set4(8'd7, 8'd3, 8'd9, 8'd1, 8'h10, 8'h11, 8'h12, 8'h13);
    send_frame(4, 1'b0, 1'b0, 1'b1);
    drain();

    send_frame(4, 1'b1, 1'b1, 1'b1);
    drain();

    set4(8'd5, 8'd2, 8'd5, 8'd2, 8'hA, 8'hB, 8'hC, 8'hD);
    send_frame(4, 1'b0, 1'b0, 1'b1);
    drain();

    set4(8'd4, 8'd2, 8'd0, 8'd0, 8'h21, 8'h22, 8'h00, 8'h00);
    send_frame(2, 1'b0, 1'b0, 1'b1);
    set4(8'd6, 8'd6, 8'd1, 8'd0, 8'h31, 8'h32, 8'h33, 8'h34);
    send_frame(4, 1'b1, 1'b0, 1'b1);
    drain();

    for (int f = 0; f < 40; f++) begin
      for (int i = 0; i < int'(SIZE); i++) begin
        fk[i] = 8'($urandom_range(0, 7));
        ft[i] = 8'($urandom);
      end
      send_frame(int'($urandom_range(1, SIZE)), $urandom_range(0, 1) != 0, 1'b1, 1'b1);
      if ((f % 5) == 4) drain();
    end
    drain();

    // Reset while sorting a 2-record frame: nothing from it may surface
    set4(8'd3, 8'd1, 8'd0, 8'd0, 8'h41, 8'h42, 8'h00, 8'h00);
    send_frame(2, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check_idle_reset("midreset");
    rst_n = 1'b1;
    @(negedge clk);
    set4(8'd8, 8'd6, 8'd0, 8'd0, 8'h51, 8'h52, 8'h00, 8'h00);
    send_frame(2, 1'b0, 1'b0, 1'b1);
    drain();
    repeat (20) @(negedge clk);
    check("final_idle_busy", 32'(busy), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
